// File: rtl/cpu_pkg.sv
// Shared CPU widths and the issue-slot bundle handed from reg_manager to the ALU.
package cpu_pkg;

  localparam int unsigned xlen       = 32;
  localparam int unsigned unit_w     = 2;
  localparam int unsigned sub_unit_w = 3;
  localparam int unsigned sel_w      = 6;
  localparam int unsigned reg_addr_w = 5;

  typedef enum logic {
    EMPTY,
    FULL
  } slot_state_t;

  typedef struct packed {
    logic [unit_w-1:0]     unit;
    logic [sub_unit_w-1:0] sub_unit;
    logic [sel_w-1:0]      sel;
    logic [reg_addr_w-1:0] rd;
    logic                  imm;
    logic [xlen-1:0]       immediate;
    logic [xlen-1:0]       rs1;
    logic [xlen-1:0]       rs2;
  } issue_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on issue, cleared on writeback.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set,
  input  logic [reg_addr_w-1:0] i_set_rd,
  input  logic                  i_clr,
  input  logic [reg_addr_w-1:0] i_clr_rd,
  input  logic [NUM_REGS-1:0]   i_mask,
  input  logic [reg_addr_w-1:0] i_rs1,
  input  logic [reg_addr_w-1:0] i_rs2,
  input  logic [reg_addr_w-1:0] i_rd,
  input  logic                  i_use_rs1,
  input  logic                  i_use_rs2,
  input  logic                  i_rd_we,
  output logic                  o_hazard
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_eff;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set) w_set_mask[i_set_rd] = 1'b1;
    if (i_clr) w_clr_mask[i_clr_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending; x0 never tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
  end

  assign w_busy_eff = r_busy & ~i_mask;

  assign o_hazard = (i_use_rs1 & w_busy_eff[i_rs1])
                  | (i_use_rs2 & w_busy_eff[i_rs2])
                  | (i_rd_we   & w_busy_eff[i_rd]);

endmodule

// File: rtl/reg_manager.sv
// Register manager / issue stage: regfile, scoreboard hazard stall, single registered issue slot.
// Optional REG_MANAGER_WB_BYPASS_EN forwards same-cycle writeback into hazard check and operand read.
module reg_manager
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN     = xlen,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [unit_w-1:0]     dec_unit_i,
  input  logic [sub_unit_w-1:0] dec_sub_unit_i,
  input  logic [sel_w-1:0]      dec_sel_i,
  input  logic [reg_addr_w-1:0] dec_rs1_i,
  input  logic [reg_addr_w-1:0] dec_rs2_i,
  input  logic [reg_addr_w-1:0] dec_rd_i,
  input  logic                  dec_use_rs1_i,
  input  logic                  dec_use_rs2_i,
  input  logic                  dec_rd_we_i,
  input  logic [XLEN-1:0]       dec_immediate_i,
  input  logic                  dec_imm_i,
  output logic                  iss_valid_o,
  output logic [unit_w-1:0]     unit_o,
  output logic [sub_unit_w-1:0] sub_unit_o,
  output logic [sel_w-1:0]      sel_o,
  output logic [reg_addr_w-1:0] rd_o,
  output logic                  imm_o,
  output logic [XLEN-1:0]       rs1_o,
  output logic [XLEN-1:0]       rs2_o,
  output logic [XLEN-1:0]       immediate_o,
  input  logic                  alu_ok_i,
  input  logic                  wb_valid_i,
  input  logic [reg_addr_w-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  slot_state_t         r_state;
  slot_state_t         w_state_nxt;
  issue_t              r_slot;
  issue_t              w_slot_nxt;
  logic                w_hazard;
  logic                w_accept;
  logic                w_byp_rs1;
  logic                w_byp_rs2;
  logic [NUM_REGS-1:0] w_byp_mask;
  logic [XLEN-1:0]     w_rs1_val;
  logic [XLEN-1:0]     w_rs2_val;

`ifdef REG_MANAGER_WB_BYPASS_EN
  always_comb begin
    w_byp_mask = '0;
    if (wb_valid_i) w_byp_mask[wb_rd_i] = 1'b1;
  end
  assign w_byp_rs1 = wb_valid_i && (wb_rd_i == dec_rs1_i);
  assign w_byp_rs2 = wb_valid_i && (wb_rd_i == dec_rs2_i);
`else
  assign w_byp_mask = '0;
  assign w_byp_rs1  = 1'b0;
  assign w_byp_rs2  = 1'b0;
`endif

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (w_accept && dec_rd_we_i),
    .i_set_rd (dec_rd_i),
    .i_clr    (wb_valid_i),
    .i_clr_rd (wb_rd_i),
    .i_mask   (w_byp_mask),
    .i_rs1    (dec_rs1_i),
    .i_rs2    (dec_rs2_i),
    .i_rd     (dec_rd_i),
    .i_use_rs1(dec_use_rs1_i),
    .i_use_rs2(dec_use_rs2_i),
    .i_rd_we  (dec_rd_we_i),
    .o_hazard (w_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_valid_i && (wb_rd_i != '0)) begin
      r_regs[wb_rd_i] <= wb_data_i;
    end
  end

  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (dec_use_rs1_i && (dec_rs1_i != '0)) w_rs1_val = w_byp_rs1 ? wb_data_i : r_regs[dec_rs1_i];
    if (dec_use_rs2_i && (dec_rs2_i != '0)) w_rs2_val = w_byp_rs2 ? wb_data_i : r_regs[dec_rs2_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_state_nxt = FULL;
      FULL:  if (!w_accept && alu_ok_i) w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    iss_valid_o = (r_state == FULL);
    dec_ready_o = !w_hazard && ((r_state == EMPTY) || alu_ok_i);
  end

  assign w_accept = dec_valid_i && dec_ready_o;

  always_comb begin
    w_slot_nxt           = '0;
    w_slot_nxt.unit      = dec_unit_i;
    w_slot_nxt.sub_unit  = dec_sub_unit_i;
    w_slot_nxt.sel       = dec_sel_i;
    w_slot_nxt.rd        = dec_rd_i;
    w_slot_nxt.imm       = dec_imm_i;
    w_slot_nxt.immediate = dec_immediate_i;
    w_slot_nxt.rs1       = w_rs1_val;
    w_slot_nxt.rs2       = w_rs2_val;
  end

  // Slot contents only change on accept, so a stalled ALU sees stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_slot <= '0;
    else if (w_accept) r_slot <= w_slot_nxt;
  end

  assign unit_o      = r_slot.unit;
  assign sub_unit_o  = r_slot.sub_unit;
  assign sel_o       = r_slot.sel;
  assign rd_o        = r_slot.rd;
  assign imm_o       = r_slot.imm;
  assign immediate_o = r_slot.immediate;
  assign rs1_o       = r_slot.rs1;
  assign rs2_o       = r_slot.rs2;

endmodule

// File: doc/reg_manager.md
# reg_manager

Register manager and issue stage directly upstream of the ALU. Accepts decoded operations from the decoder over a valid/ready handshake and reads rs1/rs2 from the integer register file. Tracks pending destinations in a scoreboard, stalls on RAW/WAW hazards, and presents one registered operation per cycle to the ALU. Also owns the register file write port, fed by ALU writeback.

## Interface
- XLEN, 32: datapath width; must equal cpu_pkg::xlen.
- NUM_REGS, 32: architectural integer registers; register 0 is hard-wired zero.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid_i  in  1  decoder presents an operation
- dec_ready_o  out  1  operation accepted this cycle when high with dec_valid_i
- dec_unit_i / dec_sub_unit_i / dec_sel_i  in  2/3/6  ALU opcode fields
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  5 each  register addresses
- dec_use_rs1_i, dec_use_rs2_i, dec_rd_we_i  in  1 each  operand used / destination written
- dec_immediate_i  in  XLEN  immediate; dec_imm_i  in  1  select immediate as operand b
- iss_valid_o  out  1  issue slot holds an operation
- unit_o, sub_unit_o, sel_o, rd_o, imm_o  out  2/3/6/5/1  registered opcode fields to ALU
- rs1_o, rs2_o, immediate_o  out  XLEN each  registered operand values
- alu_ok_i  in  1  ALU consumes the issued operation this cycle
- wb_valid_i  in  1  ALU result writeback
- wb_rd_i  in  5  writeback destination; wb_data_i  in  XLEN  result

## Operation
- Issue slot states: EMPTY, FULL. EMPTY→FULL on accept; FULL→EMPTY on alu_ok_i without accept; FULL→FULL on alu_ok_i with accept (replace); FULL with no alu_ok_i holds all outputs stable.
- Hazard = (dec_use_rs1_i & busy[rs1]) | (dec_use_rs2_i & busy[rs2]) | (dec_rd_we_i & busy[rd]); busy[0] is always 0.
- dec_ready_o = !hazard & (slot EMPTY | alu_ok_i). Combinational from dec_* inputs; decoder holds inputs stable while valid & !ready.
- On accept: capture opcode fields, rd, imm, immediate; rs1_o/rs2_o = regfile read (0 for x0 or unused operand). Set busy[rd] if dec_rd_we_i and rd≠0.
- Writeback: wb_valid_i writes regfile[wb_rd_i] and clears busy[wb_rd_i]; wb_rd_i=0 ignored. Writeback to a non-busy register is still written (no error).
- Same-cycle set and clear of one busy bit: set wins.

## Timing
- Reset: iss_valid_o=0, all opcode/operand outputs 0, busy all 0, regfile all 0; dec_ready_o=1 while dec_valid_i has no hazard.
- Accept→iss_valid_o: 1 cycle. Writeback→register visible to read: next cycle (no bypass) or same cycle (bypass).
- Back-to-back dependent op without bypass: earliest issue is the cycle after wb_valid_i.
- Reset asserted mid-operation drops the slot and all busy bits immediately; outputs reach reset values asynchronously.

## Configuration
- REG_MANAGER_WB_BYPASS_EN defined: a same-cycle wb_valid_i to register r masks busy[r] in the hazard check, and the read of r returns wb_data_i. Removes the 1-cycle RAW bubble.
- Undefined: hazard uses registered busy only; reads see the regfile only.

## Structure
- cpu_pkg: xlen, widths of unit/sub_unit/sel, register-address width, and an issue_t struct bundling the issue-slot fields.
- One sub-module, reg_scoreboard: the busy-bit vector with set/clear ports and hazard lookup. Regfile and issue slot stay inline.

## Test plan
- Reset, then accept addi x1,x0,5 (imm=1, immediate=5) -> iss_valid_o=1 next cycle, rs1_o=0, immediate_o=5, rd_o=1, busy[1]=1.
- After wb x1=5, issue add x2,x1,x1 -> rs1_o=rs2_o=5. With a pending x1 write: stalls, dec_ready_o=0 until wb_valid_i (without bypass, issue the next cycle).
- Slot FULL, alu_ok_i=0 for 3 cycles -> outputs held, dec_ready_o=0. Then alu_ok_i=1 with new dec_valid_i -> replace in the same cycle.
- wb_valid_i to x0 with data 0xDEAD -> later read of x0 returns 0; busy[0] never set by rd=0.
- Issue to rd=3 in the same cycle wb clears x3 (bypass build) -> busy[3]=1 afterwards.
- Assert rst_n=0 with slot FULL and busy[7]=1 -> iss_valid_o=0 and busy cleared without waiting for clk.
